uart_apb_host: RTL and testbench

UART_APB_HOST -- requirements
Module: uart_apb_host

---
 rtl/uart_apb_pkg.sv | 34 +++
 rtl/uart_apb_xfer.sv | 70 +++++++
 rtl/uart_apb_host.sv | 169 ++++++++++++++++
 tb/tb_uart_apb_host.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB host: register map, STATUS bit positions, FSM states.
package uart_apb_pkg;

    // UART register offsets
    localparam logic [4:0] ADDR_TX     = 5'h00;
    localparam logic [4:0] ADDR_RX     = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    // STATUS register bit indices
    localparam int unsigned ST_TXRDY    = 0;
    localparam int unsigned ST_RXRDY    = 1;
    localparam int unsigned ST_PARITY   = 2;
    localparam int unsigned ST_OVERFLOW = 3;
    localparam int unsigned ST_FRAMING  = 4;

    typedef enum logic [2:0] {
        StCfg1,
        StCfg2,
        StCfg3,
        StPoll,
        StRxrd,
        StTxwr,
        StGap
    } state_e;

    // CTRL2 layout: {baud[12:8], odd_n_even, parity_en, bit8}
    function automatic logic [7:0] ctrl2_val(logic [12:0] baud, logic odd, logic par, logic bit8);
        return {baud[12:8], odd, par, bit8};
    endfunction

endpackage

// File: rtl/uart_apb_xfer.sv
// Two-phase APB master transfer engine. SETUP is decoded combinationally from req so a new
// transfer can start in the cycle right after the previous one completes.
module uart_apb_xfer
    import uart_apb_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       req,
    input  logic [4:0] addr,
    input  logic       write,
    input  logic [7:0] wdata,
    output logic       setup,
    output logic       done,
    output logic [7:0] rdata,
    output logic       slverr,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    logic       access_q;
    logic [4:0] addr_q;
    logic       write_q;
    logic [7:0] wdata_q;

    // Capture the request on its SETUP cycle so the bus holds steady through wait states.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            access_q <= 1'b0;
            addr_q   <= 5'h00;
            write_q  <= 1'b0;
            wdata_q  <= 8'h00;
        end else if (setup) begin
            access_q <= 1'b1;
            addr_q   <= addr;
            write_q  <= write;
            wdata_q  <= write ? wdata : 8'h00;
        end else if (done) begin
            access_q <= 1'b0;
        end
    end

    // Bus outputs: live request during SETUP, latched copy during ACCESS, zero when idle.
    always_comb begin
        setup   = req && !access_q;
        done    = access_q && PREADY;
        rdata   = PRDATA;
        slverr  = PSLVERR;
        PSEL    = setup || access_q;
        PENABLE = access_q;
        PADDR   = 5'h00;
        PWRITE  = 1'b0;
        PWDATA  = 8'h00;
        if (access_q) begin
            PADDR  = addr_q;
            PWRITE = write_q;
            PWDATA = wdata_q;
        end else if (setup) begin
            PADDR  = addr;
            PWRITE = write;
            PWDATA = write ? wdata : 8'h00;
        end
    end

endmodule

// File: rtl/uart_apb_host.sv
// Configures a UART over APB, then polls STATUS to move bytes between the UART and
// the s_tx / m_rx streams. RX is serviced ahead of TX.
module uart_apb_host
    import uart_apb_pkg::*;
#(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter bit          BIT8       = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          ODD_N_EVEN = 1'b0,
    parameter logic [2:0]  BAUD_FRCTN = 3'd0,
    parameter int unsigned POLL_GAP   = 0
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       s_tx_valid,
    output logic       s_tx_ready,
    input  logic [7:0] s_tx_data,
    output logic       m_rx_valid,
    input  logic       m_rx_ready,
    output logic [7:0] m_rx_data,
    output logic [2:0] m_rx_err,
    output logic       cfg_done,
    output logic       apb_err,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    // GAP always lasts at least one cycle so polls are separated by an idle bus cycle.
    localparam logic [7:0] GAP_LAST = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    state_e     state_q, state_d;
    logic       run_q;
    logic [7:0] gap_q;
    logic [2:0] stat_err_q;
    logic       m_rx_valid_q;
    logic [7:0] m_rx_data_q;
    logic [2:0] m_rx_err_q;
    logic       cfg_done_q;
    logic       apb_err_q;

    logic       req, wr, setup, done, slverr;
    logic [4:0] addr;
    logic [7:0] wdata, rdata;
    logic       gap_end;

    assign gap_end    = (gap_q == GAP_LAST);
    assign m_rx_valid = m_rx_valid_q;
    assign m_rx_data  = m_rx_data_q;
    assign m_rx_err   = m_rx_err_q;
    assign cfg_done   = cfg_done_q;
    assign apb_err    = apb_err_q;

    uart_apb_xfer u_xfer (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .req     (req),
        .addr    (addr),
        .write   (wr),
        .wdata   (wdata),
        .setup   (setup),
        .done    (done),
        .rdata   (rdata),
        .slverr  (slverr),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    // State register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state_q <= StCfg1;
        else          state_q <= state_d;
    end

    // Next-state: configuration chain, then POLL dispatching to RX, TX or an idle gap
    always_comb begin
        state_d = state_q;
        case (state_q)
            StCfg1: if (done) state_d = StCfg2;
            StCfg2: if (done) state_d = StCfg3;
            StCfg3: if (done) state_d = StPoll;
            StPoll: begin
                if (done) begin
                    if (rdata[ST_RXRDY] && !m_rx_valid_q)   state_d = StRxrd;
                    else if (rdata[ST_TXRDY] && s_tx_valid) state_d = StTxwr;
                    else                                    state_d = StGap;
                end
            end
            StRxrd, StTxwr: if (done) state_d = StPoll;
            StGap: if (gap_end) state_d = StPoll;
            default: state_d = StCfg1;
        endcase
    end

    // Outputs: transfer request per state and the TX accept pulse on the TXWR SETUP cycle
    always_comb begin
        req   = run_q;
        addr  = ADDR_STATUS;
        wr    = 1'b0;
        wdata = 8'h00;
        case (state_q)
            StCfg1: begin
                addr  = ADDR_CTRL1;
                wr    = 1'b1;
                wdata = BAUD_VALUE[7:0];
            end
            StCfg2: begin
                addr  = ADDR_CTRL2;
                wr    = 1'b1;
                wdata = ctrl2_val(BAUD_VALUE, ODD_N_EVEN, PARITY_EN, BIT8);
            end
            StCfg3: begin
                addr  = ADDR_CTRL3;
                wr    = 1'b1;
                wdata = {5'b0, BAUD_FRCTN};
            end
            StPoll: addr = ADDR_STATUS;
            StRxrd: addr = ADDR_RX;
            StTxwr: begin
                addr  = ADDR_TX;
                wr    = 1'b1;
                wdata = s_tx_data;
            end
            default: req = 1'b0;
        endcase
        s_tx_ready = (state_q == StTxwr) && setup;
    end

    // Datapath: gap counter, STATUS error capture, RX holding register, sticky flags
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            run_q        <= 1'b0;
            gap_q        <= 8'h00;
            stat_err_q   <= 3'b000;
            m_rx_valid_q <= 1'b0;
            m_rx_data_q  <= 8'h00;
            m_rx_err_q   <= 3'b000;
            cfg_done_q   <= 1'b0;
            apb_err_q    <= 1'b0;
        end else begin
            // run_q holds the bus idle for the first cycle out of reset
            run_q <= 1'b1;
            gap_q <= (state_q == StGap && !gap_end) ? gap_q + 8'd1 : 8'h00;
            if (state_q == StPoll && done) begin
                stat_err_q <= {rdata[ST_FRAMING], rdata[ST_OVERFLOW], rdata[ST_PARITY]};
            end
            if (m_rx_valid_q && m_rx_ready) m_rx_valid_q <= 1'b0;
            if (state_q == StRxrd && done) begin
                m_rx_valid_q <= 1'b1;
                m_rx_data_q  <= rdata;
                m_rx_err_q   <= stat_err_q;
            end
            if (state_q == StCfg3 && done) cfg_done_q <= 1'b1;
            if (done && slverr) apb_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_apb_host.sv
// Self-checking bench for uart_apb_host: an APB slave model with programmable wait states and
// error response, a transfer log, and directed/randomized scenarios checked against a model.
module tb_uart_apb_host;

    localparam logic [12:0] BAUD  = 13'h0123;
    localparam bit          B8    = 1'b1;
    localparam bit          PAR   = 1'b1;
    localparam bit          ODD   = 1'b0;
    localparam logic [2:0]  FRCTN = 3'd5;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic       s_tx_valid = 1'b0;
    logic       s_tx_ready;
    logic [7:0] s_tx_data = 8'h00;
    logic       m_rx_valid;
    logic       m_rx_ready = 1'b0;
    logic [7:0] m_rx_data;
    logic [2:0] m_rx_err;
    logic       cfg_done, apb_err;
    logic [4:0] PADDR;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    always #5 PCLK = ~PCLK;

    uart_apb_host #(
        .BAUD_VALUE (BAUD),
        .BIT8       (B8),
        .PARITY_EN  (PAR),
        .ODD_N_EVEN (ODD),
        .BAUD_FRCTN (FRCTN),
        .POLL_GAP   (2)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .s_tx_valid (s_tx_valid),
        .s_tx_ready (s_tx_ready),
        .s_tx_data  (s_tx_data),
        .m_rx_valid (m_rx_valid),
        .m_rx_ready (m_rx_ready),
        .m_rx_data  (m_rx_data),
        .m_rx_err   (m_rx_err),
        .cfg_done   (cfg_done),
        .apb_err    (apb_err),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    // APB slave model
    int unsigned wait_n   = 0;
    int unsigned wcnt     = 0;
    logic        slverr_v = 1'b0;
    logic [7:0]  status_v = 8'h00;
    logic [7:0]  rx_v     = 8'h00;

    assign PREADY  = PSEL && PENABLE && (wcnt >= wait_n);
    assign PRDATA  = (PADDR == 5'h10) ? status_v : (PADDR == 5'h04) ? rx_v : 8'h00;
    assign PSLVERR = PREADY && slverr_v;

    always @(posedge PCLK) wcnt <= (PSEL && PENABLE && !PREADY) ? wcnt + 1 : 0;

    // Transfer log and bus-protocol monitor, sampled mid-cycle
    typedef struct {
        logic [4:0]  addr;
        logic        write;
        logic [7:0]  wdata;
        int unsigned acc;
    } xfer_t;

    xfer_t       log_q[$];
    logic [4:0]  su_addr  = 5'h00;
    logic        su_write = 1'b0;
    logic [7:0]  su_wdata = 8'h00;
    int unsigned acc_n = 0, proto_bad = 0, tx_pulses = 0, tx_bad = 0;

    always @(negedge PCLK) begin
        if (PSEL && !PENABLE) begin
            su_addr  <= PADDR;
            su_write <= PWRITE;
            su_wdata <= PWDATA;
            acc_n    <= 0;
        end else if (PSEL && PENABLE) begin
            acc_n <= acc_n + 1;
            if ({PADDR, PWRITE, PWDATA} !== {su_addr, su_write, su_wdata})
                proto_bad <= proto_bad + 1;
            if (PREADY)
                log_q.push_back('{addr: PADDR, write: PWRITE, wdata: PWDATA, acc: acc_n + 1});
        end
        if (s_tx_ready) begin
            tx_pulses <= tx_pulses + 1;
            if (!(PSEL && !PENABLE && PWRITE && PADDR == 5'h00)) tx_bad <= tx_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
        end
    endtask

    // Next completed transfer, bounded by a cycle budget
    task automatic pop(output xfer_t x);
        bit got = 1'b0;
        int unsigned i = 0;
        x = '{addr: 5'h1f, write: 1'b0, wdata: 8'h00, acc: 0};
        while (!got && i < 300) begin
            if (log_q.size() > 0) begin
                x = log_q.pop_front();
                got = 1'b1;
            end else begin
                @(negedge PCLK);
                #1;
                i++;
            end
        end
        if (!got) chk("xfer_timeout", {31'b0, got}, 32'd1);
    endtask

    // Next transfer that is not a STATUS poll
    task automatic pop_nonpoll(output xfer_t x);
        int n = 0;
        pop(x);
        while (x.addr == 5'h10 && !x.write && n < 40) begin
            pop(x);
            n++;
        end
    endtask

    task automatic tx_case(input logic [7:0] d);
        xfer_t x;
        int unsigned p0;
        log_q.delete();
        p0 = tx_pulses;
        s_tx_data  = d;
        s_tx_valid = 1'b1;
        status_v   = 8'h01;
        pop_nonpoll(x);
        s_tx_valid = 1'b0;
        s_tx_data  = ~d;
        status_v   = 8'h00;
        chk("tx_write", {18'b0, x.addr, x.write, x.wdata}, {18'b0, 5'h00, 1'b1, d});
        repeat (8) @(negedge PCLK);
        #1;
        chk("tx_pulse_count", tx_pulses - p0, 1);
    endtask

    task automatic rx_case(input logic [7:0] st, input logic [7:0] d);
        xfer_t x;
        logic [2:0] exp_err;
        exp_err = 3'((st >> 2) & 8'h07);
        log_q.delete();
        rx_v     = d;
        status_v = st;
        pop_nonpoll(x);
        status_v = 8'h00;
        chk("rx_read", {26'b0, x.addr, x.write}, {26'b0, 5'h04, 1'b0});
        @(posedge PCLK);
        #1;
        chk("rx_valid", {31'b0, m_rx_valid}, 1);
        chk("rx_data", {24'b0, m_rx_data}, {24'b0, d});
        chk("rx_err", {29'b0, m_rx_err}, {29'b0, exp_err});
        rx_v = ~d;
        repeat (6) @(negedge PCLK);
        chk("rx_hold", {20'b0, m_rx_valid, m_rx_data, m_rx_err}, {20'b0, 1'b1, d, exp_err});
        m_rx_ready = 1'b1;
        @(posedge PCLK);
        #1;
        m_rx_ready = 1'b0;
        chk("rx_release", {31'b0, m_rx_valid}, 0);
    endtask

    initial begin
        xfer_t       x;
        logic [7:0]  cfg_addr[3];
        logic [7:0]  cfg_data[3];
        logic [7:0]  d, rd, st;
        bit          hit;

        // Expected configuration writes
        cfg_addr[0] = 8'h08;
        cfg_addr[1] = 8'h0C;
        cfg_addr[2] = 8'h14;
        cfg_data[0] = 8'(BAUD % 256);
        cfg_data[1] = 8'((BAUD / 256) * 8 + ODD * 4 + PAR * 2 + B8);
        cfg_data[2] = 8'(FRCTN);

        repeat (3) @(negedge PCLK);
        #1;
        chk("rst_apb", {19'b0, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        chk("rst_host", {12'b0, s_tx_ready, m_rx_valid, m_rx_data, m_rx_err, cfg_done, apb_err}, 0);
        PRESETN = 1'b1;

        for (int i = 0; i < 3; i++) begin
            pop(x);
            chk($sformatf("cfg_write%0d", i), {18'b0, x.addr, x.write, x.wdata},
                {18'b0, cfg_addr[i][4:0], 1'b1, cfg_data[i]});
            if (i == 2) chk("cfg_done_early", {31'b0, cfg_done}, 0);
        end
        @(posedge PCLK);
        #1;
        chk("cfg_done", {31'b0, cfg_done}, 1);
        pop(x);
        chk("first_poll", {26'b0, x.addr, x.write}, {26'b0, 5'h10, 1'b0});

        // TX: directed byte then random bytes
        tx_case(8'hA5);
        for (int i = 0; i < 2; i++) tx_case(8'($urandom_range(0, 255)));

        // RX: directed STATUS/data then random error patterns
        rx_case(8'h1A, 8'h3C);
        for (int i = 0; i < 2; i++) begin
            st = 8'(($urandom_range(0, 7) << 2) | 2 | $urandom_range(0, 1));
            rx_case(st, 8'($urandom_range(0, 255)));
        end

        // Contention: RX serviced first, TX on the following poll
        log_q.delete();
        d  = 8'($urandom_range(0, 255));
        rd = 8'($urandom_range(0, 255));
        rx_v       = rd;
        s_tx_data  = d;
        s_tx_valid = 1'b1;
        status_v   = 8'h03;
        pop_nonpoll(x);
        chk("cont_rx_first", {26'b0, x.addr, x.write}, {26'b0, 5'h04, 1'b0});
        pop(x);
        chk("cont_poll_between", {26'b0, x.addr, x.write}, {26'b0, 5'h10, 1'b0});
        pop(x);
        s_tx_valid = 1'b0;
        status_v   = 8'h00;
        chk("cont_tx_next", {18'b0, x.addr, x.write, x.wdata}, {18'b0, 5'h00, 1'b1, d});
        chk("cont_rx_data", {24'b0, m_rx_data}, {24'b0, rd});
        m_rx_ready = 1'b1;
        @(posedge PCLK);
        #1;
        m_rx_ready = 1'b0;

        // Wait states plus PSLVERR on an RX read: byte still delivered, error flag sticky
        log_q.delete();
        d  = 8'($urandom_range(0, 255));
        st = 8'(($urandom_range(0, 7) << 2) | 2);
        chk("apb_err_clear", {31'b0, apb_err}, 0);
        wait_n   = 3;
        slverr_v = 1'b1;
        rx_v     = d;
        status_v = st;
        pop_nonpoll(x);
        status_v = 8'h00;
        chk("err_rx_read", {26'b0, x.addr, x.write}, {26'b0, 5'h04, 1'b0});
        chk("err_access_len", x.acc, 4);
        @(posedge PCLK);
        #1;
        wait_n   = 0;
        slverr_v = 1'b0;
        chk("apb_err_set", {31'b0, apb_err}, 1);
        chk("err_rx_data", {24'b0, m_rx_data}, {24'b0, d});
        chk("err_rx_err", {29'b0, m_rx_err}, {29'b0, 3'((st >> 2) & 8'h07)});
        pop(x);
        chk("err_continue_poll", {26'b0, x.addr, x.write}, {26'b0, 5'h10, 1'b0});
        chk("apb_err_sticky", {31'b0, apb_err}, 1);

        // Reset in the middle of a TX write ACCESS, with an undelivered RX byte pending
        chk("pending_rx", {31'b0, m_rx_valid}, 1);
        log_q.delete();
        wait_n     = 3;
        s_tx_data  = 8'($urandom_range(0, 255));
        s_tx_valid = 1'b1;
        status_v   = 8'h01;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge PCLK);
            #1;
            if (PSEL && PENABLE && PWRITE && PADDR == 5'h00) hit = 1'b1;
        end
        chk("reach_txwr_access", {31'b0, hit}, 1);
        PRESETN = 1'b0;
        #1;
        chk("rst_async_apb", {19'b0, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        chk("rst_async_host",
            {12'b0, s_tx_ready, m_rx_valid, m_rx_data, m_rx_err, cfg_done, apb_err}, 0);
        s_tx_valid = 1'b0;
        wait_n     = 0;
        status_v   = 8'h00;
        repeat (2) @(negedge PCLK);
        #1;
        log_q.delete();
        PRESETN = 1'b1;
        pop(x);
        chk("restart_cfg1", {18'b0, x.addr, x.write, x.wdata},
            {18'b0, cfg_addr[0][4:0], 1'b1, cfg_data[0]});

        chk("bus_stable", proto_bad, 0);
        chk("tx_pulse_in_setup", tx_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
